// File: rtl/argmax_pkg.sv
// Shared types and constants for the streaming argmax.
// Holds the FSM encoding, a clog2 helper and default sizes.
package argmax_pkg;

  typedef enum logic {
    S_ACC  = 1'b0,
    S_DONE = 1'b1
  } state_t;

  localparam int DEF_NUM_CLASSES = 10;
  localparam int DEF_SCORE_W     = 8;

  // Never returns less than 1 so a counter always has a bit.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/argmax_cmp.sv
// Combinational a > b, signed or unsigned by parameter.
// Ports: a, b (SCORE_W) in; gt out.
module argmax_cmp
  import argmax_pkg::*;
#(
  parameter int SCORE_W       = DEF_SCORE_W,
  parameter int SIGNED_SCORES = 0
) (
  input  logic [SCORE_W-1:0] a,
  input  logic [SCORE_W-1:0] b,
  output logic               gt
);

  generate
    if (SIGNED_SCORES != 0) begin : g_s
      assign gt = $signed(a) > $signed(b);
    end else begin : g_u
      assign gt = a > b;
    end
  endgenerate

endmodule

// File: rtl/argmax_stream.sv
// Streaming argmax: one score per beat, winner after NUM_CLASSES.
// Ports: clk, rst (async high), flush; in_valid/in_ready/in_score;
// out_valid/out_ready/out_idx/out_score.
// ARGMAX_MARGIN_EN adds out_second_idx and out_margin.
module argmax_stream
  import argmax_pkg::*;
#(
  parameter int NUM_CLASSES   = DEF_NUM_CLASSES,
  parameter int SCORE_W       = DEF_SCORE_W,
  parameter int IDX_W         = 8,
  parameter int SIGNED_SCORES = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SCORE_W-1:0] in_score,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IDX_W-1:0]   out_idx,
  output logic [SCORE_W-1:0] out_score
`ifdef ARGMAX_MARGIN_EN
  ,
  output logic [IDX_W-1:0]   out_second_idx,
  output logic [SCORE_W:0]   out_margin
`endif
);

  localparam int CW = clog2(NUM_CLASSES);
  localparam logic [CW-1:0] LAST = CW'(NUM_CLASSES - 1);

  state_t state, nstate;
  logic   live;
  logic [CW-1:0]      cnt;
  logic [SCORE_W-1:0] best, nb;
  logic [IDX_W-1:0]   best_idx, ni;
  logic gt_best, acc, last, fl;

  // in_ready stays low until the first edge after reset releases.
  assign in_ready  = live && (state == S_ACC);
  assign out_valid = (state == S_DONE);
  assign fl   = flush && (state == S_ACC);
  assign acc  = in_valid && in_ready && !flush;
  assign last = acc && (cnt == LAST);

  argmax_cmp #(
    .SCORE_W      (SCORE_W),
    .SIGNED_SCORES(SIGNED_SCORES)
  ) u_cmp_best (
    .a (in_score),
    .b (best),
    .gt(gt_best)
  );

  // Winner including the current beat; first beat loads blindly.
  always_comb begin
    nb = best;
    ni = best_idx;
    if (cnt == '0) begin
      nb = in_score;
      ni = '0;
    end else if (gt_best) begin
      nb = in_score;
      ni = IDX_W'(cnt);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_ACC;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      S_ACC:  if (last) nstate = S_DONE;
      S_DONE: if (out_ready) nstate = S_ACC;
      default: nstate = S_ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live      <= 1'b0;
      cnt       <= '0;
      best      <= '0;
      best_idx  <= '0;
      out_idx   <= '0;
      out_score <= '0;
    end else begin
      live <= 1'b1;
      if (fl) begin
        cnt      <= '0;
        best     <= '0;
        best_idx <= '0;
      end else if (acc) begin
        best     <= nb;
        best_idx <= ni;
        cnt      <= last ? '0 : cnt + 1'b1;
        if (last) begin
          out_idx   <= ni;
          out_score <= nb;
        end
      end
    end
  end

`ifdef ARGMAX_MARGIN_EN
  logic [SCORE_W-1:0] sec, ns;
  logic [IDX_W-1:0]   sec_idx, nsi;
  logic sec_v, nsv, gt_sec;
  logic [SCORE_W:0] eb, es;

  argmax_cmp #(
    .SCORE_W      (SCORE_W),
    .SIGNED_SCORES(SIGNED_SCORES)
  ) u_cmp_sec (
    .a (in_score),
    .b (sec),
    .gt(gt_sec)
  );

  // Displaced best drops to second; otherwise the beat may claim
  // second if it is the first loser or strictly beats it.
  always_comb begin
    ns  = sec;
    nsi = sec_idx;
    nsv = sec_v;
    if (cnt == '0) begin
      ns  = '0;
      nsi = '0;
      nsv = 1'b0;
    end else if (gt_best) begin
      ns  = best;
      nsi = best_idx;
      nsv = 1'b1;
    end else if (!sec_v || gt_sec) begin
      ns  = in_score;
      nsi = IDX_W'(cnt);
      nsv = 1'b1;
    end
  end

  // One extra bit keeps the signed difference non-negative.
  assign eb = (SIGNED_SCORES != 0) ? {nb[SCORE_W-1], nb}
                                   : {1'b0, nb};
  assign es = (SIGNED_SCORES != 0) ? {ns[SCORE_W-1], ns}
                                   : {1'b0, ns};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec            <= '0;
      sec_idx        <= '0;
      sec_v          <= 1'b0;
      out_second_idx <= '0;
      out_margin     <= '0;
    end else if (fl) begin
      sec     <= '0;
      sec_idx <= '0;
      sec_v   <= 1'b0;
    end else if (acc) begin
      sec     <= ns;
      sec_idx <= nsi;
      sec_v   <= nsv;
      if (last) begin
        out_second_idx <= nsi;
        out_margin     <= eb - es;
      end
    end
  end
`endif

endmodule

// File: doc/argmax_stream.md
Name: argmax_stream

Overview:
- Sequential, parametrised classifier back-end: picks the winning class from a neural-network output layer.
- Accepts NUM_CLASSES scores, one per valid/ready beat, tracks the running maximum, then presents the winning index and its score.
- Replaces the flat-vector combinational argmax.
- Sits between the last-layer neuron array and the result/UART logic.
- Supports signed or unsigned scores and output backpressure.

Parameters:
- NUM_CLASSES, 10: scores per frame, >= 2.
- SCORE_W, 8: bits per score.
- IDX_W, 8: output index width; must be >= clog2(NUM_CLASSES).
- SIGNED_SCORES, 0: 1 = two's-complement comparison; 0 = unsigned comparison.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous frame abort.
- in_valid  in  1  in_score is valid.
- in_ready  out  1  block can accept a score.
- in_score  in  SCORE_W  current class score; class order is arrival order.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- out_idx  out  IDX_W  index of the winning class.
- out_score  out  SCORE_W  score of the winning class.

Behaviour:
- Clock and reset: one clock (clk). rst is asynchronous, active-high; it clears everything immediately, independent of clk.
- Reset values:
  - state = S_ACC, cnt = 0, best = 0, best_idx = 0.
  - out_valid = 0, out_idx = 0, out_score = 0.
  - in_ready = 0 while rst is high; in_ready = 1 from the first edge after rst falls.
- Handshakes:
  - A beat is accepted when in_valid && in_ready on a rising edge.
  - A result is consumed when out_valid && out_ready on a rising edge.
- State machine (2 states):
  - S_ACC: in_ready = 1, out_valid = 0.
    - Accepted beat with cnt == 0: best <= in_score, best_idx <= 0 (unconditional load).
    - Accepted beat with cnt > 0 and in_score strictly greater than best: best <= in_score, best_idx <= cnt.
    - cnt increments on every accepted beat.
    - Accepting the beat with cnt == NUM_CLASSES-1: go to S_DONE, cnt <= 0, out_idx/out_score <= final winner (including that last beat).
  - S_DONE: in_ready = 0, out_valid = 1.
    - out_idx and out_score are held stable until consumed.
    - On consume: go to S_ACC.
- Latency and throughput:
  - out_valid rises on the edge that accepts the last beat, i.e. visible the cycle after.
  - At least one bubble cycle between frames, since in_ready = 0 in S_DONE.
  - Best case: NUM_CLASSES + 1 cycles per frame.
- Ties: strict greater-than, so the lowest index wins.
- Comparison: sign-aware when SIGNED_SCORES = 1, e.g. 8'h80 (-128) < 8'h7F. Unsigned otherwise.
- flush:
  - In S_ACC: cnt <= 0 and best <= 0; any beat in the same cycle is discarded.
  - In S_DONE: ignored; the result is preserved.
  - flush and rst together: rst dominates.
- Reset mid-frame: partial frame is discarded and outputs return to reset values.
- cnt is clog2(NUM_CLASSES) bits; it never exceeds NUM_CLASSES-1, so no wrap beyond the frame.
- in_score is ignored when in_valid = 0; gaps between beats are allowed.

Optional Feature:
- Macro: ARGMAX_MARGIN_EN.
- When defined:
  - Adds out_second_idx (IDX_W) and out_margin (SCORE_W+1, unsigned) = best - second_best.
  - Runner-up tracking on each accepted beat: if the new score beats best, the old best becomes second. Else if it strictly beats second (or second is unset), it becomes second.
  - Ties with best do not displace best; they do displace the runner-up only if strictly greater than it.
  - Both outputs reset to 0 and are held with out_valid.
- When undefined: these ports and registers do not exist; behaviour is otherwise identical.

Decomposition:
- Package argmax_pkg holds:
  - state encoding S_ACC = 1'b0, S_DONE = 1'b1;
  - clog2 constant function;
  - default localparams (NUM_CLASSES = 10, SCORE_W = 8).
- One natural sub-module, argmax_cmp: parametrised combinational greater-than (SCORE_W, SIGNED_SCORES). Instantiated once, or twice with ARGMAX_MARGIN_EN.

Test Plan:
- Unsigned basic: stream 10 scores 3,9,1,0,4,2,8,255,7,5, out_ready = 1 → out_valid for one cycle, out_idx = 7, out_score = 8'hFF, then in_ready = 1.
- Ties: scores all 8'h20 except idx 2 and 6 = 8'h40 → out_idx = 2, out_score = 8'h40.
- Signed (SIGNED_SCORES = 1): scores 8'h80, 8'hFE, 8'hF0, others 8'h90 → out_idx = 1, out_score = 8'hFE; with SIGNED_SCORES = 0 the same frame gives out_idx = 1 (0xFE is the largest unsigned too). Add a frame where 8'h80 vs 8'h7F flips the result between modes.
- Backpressure and gaps:
  - random in_valid gaps, out_ready held low for 5 cycles → out_idx/out_score stable, in_ready = 0 throughout;
  - next frame accepted only after consume.
- flush/reset mid-frame:
  - flush after 4 beats, then a fresh 10-beat frame → result reflects only the fresh frame;
  - async rst pulse mid-frame → out_valid = 0 and in_ready = 0 immediately, full frame required afterwards.
- ARGMAX_MARGIN_EN: frame max 8'h50 at idx 3, runner-up 8'h30 at idx 8 → out_second_idx = 8, out_margin = 9'h020.
